// File: rtl/operand_entry_pkg.sv
// Shared definitions for the calculator input front end: op codes (also used by the
// calculator core) and the operand-entry FSM state encoding.
package operand_entry_pkg;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;

    typedef enum logic [1:0] {
        ST_ENTER_A = 2'd0,
        ST_ENTER_B = 2'd1,
        ST_LOADED  = 2'd2,
        ST_ISSUE   = 2'd3
    } state_t;

endpackage

// File: rtl/operand_entry_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, hold-time debounce counter and a
// one-cycle pulse on each accepted press (stable 0->1). Rise-to-pulse is DEBOUNCE_CYCLES+3.
module btn_debounce
    import operand_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8388608
) (
    input  logic clk,
    input  logic clr,
    input  logic raw,
    output logic press_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          sync_p0;
    logic          sync_p1;
    logic          stable;
    logic          stable_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            sync_p0     <= 1'b0;
            sync_p1     <= 1'b0;
            stable      <= 1'b0;
            stable_q    <= 1'b0;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            // synchroniser stage boundary
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            // any return to the stable level restarts the hold count
            if (sync_p1 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync_p1;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            stable_q    <= stable;
            press_pulse <= stable & ~stable_q;
        end
    end

endmodule

// File: rtl/operand_entry.sv
// Calculator input front end: debounced buttons drive serial MSB-first entry of
// operands A and B, op selection, and a valid/ready request to the calculator core.
module operand_entry
    import operand_entry_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 8388608
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     x1,
    input  logic                     x0,
    input  logic                     add,
    input  logic                     sub,
    input  logic                     result,
    output logic [WIDTH-1:0]         op_a,
    output logic [WIDTH-1:0]         op_b,
    output logic [1:0]               op_code,
    output logic                     entering_b,
    output logic [$clog2(WIDTH)-1:0] bit_idx,
    output logic                     req_valid,
    input  logic                     req_ready
);

    localparam int IW = $clog2(WIDTH);

    logic [4:0] raw_btn;
    logic [4:0] pulse;
    logic       x1_p, x0_p, add_p, sub_p, result_p;

    assign raw_btn = {x1, x0, add, sub, result};
    assign {x1_p, x0_p, add_p, sub_p, result_p} = pulse;

    for (genvar g = 0; g < 5; g++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .clk         (clk),
            .clr         (clr),
            .raw         (raw_btn[g]),
            .press_pulse (pulse[g])
        );
    end

    state_t           state, state_n;
    logic [WIDTH-1:0] op_a_n, op_b_n;
    logic [1:0]       op_code_n;
    logic [IW-1:0]    bit_idx_n;
    logic             req_valid_n;
    logic             bit_one, bit_wr;

    assign bit_one    = x1_p & ~x0_p;
    assign bit_wr     = x1_p ^ x0_p;
    assign entering_b = (state == ST_ENTER_B);

    always_comb begin
        state_n     = state;
        op_a_n      = op_a;
        op_b_n      = op_b;
        op_code_n   = op_code;
        bit_idx_n   = bit_idx;
        req_valid_n = req_valid;

        // op select lands first so a same-cycle result press sees the new code
        if (state != ST_ISSUE) begin
            if (add_p && !sub_p) op_code_n = OP_ADD;
            else if (sub_p && !add_p) op_code_n = OP_SUB;
        end

        case (state)
            ST_ENTER_A, ST_ENTER_B: begin
                if (bit_wr) begin
                    if (state == ST_ENTER_A) op_a_n[bit_idx] = bit_one;
                    else                     op_b_n[bit_idx] = bit_one;
                    if (bit_idx == '0) begin
                        bit_idx_n = IW'(WIDTH - 1);
                        state_n   = (state == ST_ENTER_A) ? ST_ENTER_B : ST_LOADED;
                    end else begin
                        bit_idx_n = bit_idx - IW'(1);
                    end
                end
            end
            ST_LOADED: begin
                if (bit_wr) begin
                    op_a_n[WIDTH-1] = bit_one;
                    bit_idx_n       = IW'(WIDTH - 2);
                    state_n         = ST_ENTER_A;
                end else if (result_p && op_code_n != OP_NONE) begin
                    state_n     = ST_ISSUE;
                    req_valid_n = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (req_ready) begin
                    req_valid_n = 1'b0;
                    state_n     = ST_ENTER_A;
                end
            end
            default: state_n = ST_ENTER_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= ST_ENTER_A;
            op_a      <= '0;
            op_b      <= '0;
            op_code   <= OP_NONE;
            bit_idx   <= IW'(WIDTH - 1);
            req_valid <= 1'b0;
        end else begin
            state     <= state_n;
            op_a      <= op_a_n;
            op_b      <= op_b_n;
            op_code   <= op_code_n;
            bit_idx   <= bit_idx_n;
            req_valid <= req_valid_n;
        end
    end

endmodule

// File: tb/tb_operand_entry.sv
// Directed self-checking bench for operand_entry with a short debounce window.
module tb_operand_entry;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       x1 = 1'b0, x0 = 1'b0, add = 1'b0, sub = 1'b0, result = 1'b0;
    logic [3:0] op_a, op_b;
    logic [1:0] op_code;
    logic       entering_b;
    logic [1:0] bit_idx;
    logic       req_valid;
    logic       req_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    // {op_a, op_b, op_code, entering_b, bit_idx, req_valid}
    logic [12:0] obs;
    assign obs = {op_a, op_b, op_code, entering_b, bit_idx, req_valid};

    localparam logic [12:0] RESET_VIEW = {4'h0, 4'h0, 2'b00, 1'b0, 2'd3, 1'b0};

    localparam logic [4:0] B_X1 = 5'b10000, B_X0 = 5'b01000, B_ADD = 5'b00100,
                           B_SUB = 5'b00010, B_RES = 5'b00001;

    always #5 clk = ~clk;

    operand_entry #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .clr        (clr),
        .x1         (x1),
        .x0         (x0),
        .add        (add),
        .sub        (sub),
        .result     (result),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_code    (op_code),
        .entering_b (entering_b),
        .bit_idx    (bit_idx),
        .req_valid  (req_valid),
        .req_ready  (req_ready)
    );

    task automatic do_reset();
        @(posedge clk); #1 clr = 1'b1;
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
    endtask

    task automatic press(input logic [4:0] m);
        @(posedge clk); #1 {x1, x0, add, sub, result} = m;
        repeat (10) @(posedge clk);
        #1 {x1, x0, add, sub, result} = 5'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic enter_nibble(input logic [3:0] v);
        for (int i = 3; i >= 0; i--) press(v[i] ? B_X1 : B_X0);
    endtask

    task automatic test_reset();
        @(posedge clk); #1 clr = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs !== RESET_VIEW) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", obs, RESET_VIEW);
        end
        #1 clr = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs !== RESET_VIEW) begin
            errors++;
            $display("FAIL idle_after_reset: got %h expected %h", obs, RESET_VIEW);
        end
    endtask

    task automatic test_debounce();
        do_reset();
        @(posedge clk); #1 x1 = 1'b1;
        repeat (3) @(posedge clk);
        #1 x1 = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs !== RESET_VIEW) begin
            errors++;
            $display("FAIL glitch_no_write: got %h expected %h", obs, RESET_VIEW);
        end
        // rise just after edge 0; pulse after edge 7, write visible after edge 8
        @(posedge clk); #1 x1 = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        checks++;
        if (op_a !== 4'h0) begin
            errors++;
            $display("FAIL write_not_early: op_a got %b expected %b", op_a, 4'h0);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({op_a, bit_idx} !== {4'b1000, 2'd2}) begin
            errors++;
            $display("FAIL write_latency: op_a/bit_idx got %b/%0d expected 1000/2", op_a, bit_idx);
        end
        repeat (2) @(posedge clk);
        #1 x1 = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({op_a, bit_idx} !== {4'b1000, 2'd2}) begin
            errors++;
            $display("FAIL single_write: op_a/bit_idx got %b/%0d expected 1000/2", op_a, bit_idx);
        end
    endtask

    task automatic test_transfer();
        logic [12:0] exp;
        do_reset();
        enter_nibble(4'b1011);
        checks++;
        if ({entering_b, bit_idx} !== {1'b1, 2'd3}) begin
            errors++;
            $display("FAIL enter_b_flag: got %b/%0d expected 1/3", entering_b, bit_idx);
        end
        enter_nibble(4'b0110);
        press(B_ADD);
        press(B_RES);
        exp = {4'b1011, 4'b0110, 2'b01, 1'b0, 2'd3, 1'b1};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL request_issue: got %h expected %h", obs, exp);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL hold_not_ready cycle %0d: got %h expected %h", i, obs, exp);
            end
        end
        @(posedge clk); #1 req_ready = 1'b1;
        @(posedge clk); #1 req_ready = 1'b0;
        @(negedge clk);
        exp = {4'b1011, 4'b0110, 2'b01, 1'b0, 2'd3, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL transfer_done: got %h expected %h", obs, exp);
        end
        // back in ENTER_A: next bit lands in A[3]
        press(B_X0);
        exp = {4'b0011, 4'b0110, 2'b01, 1'b0, 2'd2, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reentry_after_transfer: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_no_op();
        logic [12:0] exp;
        do_reset();
        enter_nibble(4'b1100);
        enter_nibble(4'b0011);
        press(B_RES);
        exp = {4'b1100, 4'b0011, 2'b00, 1'b0, 2'd3, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL result_without_op: got %h expected %h", obs, exp);
        end
        press(B_SUB | B_RES);
        exp = {4'b1100, 4'b0011, 2'b10, 1'b0, 2'd3, 1'b1};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL sub_with_result: got %h expected %h", obs, exp);
        end
        @(posedge clk); #1 req_ready = 1'b1;
        @(posedge clk); #1 req_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (req_valid !== 1'b0) begin
            errors++;
            $display("FAIL sub_transfer: req_valid got %b expected 0", req_valid);
        end
    endtask

    task automatic test_conflicts();
        do_reset();
        press(B_X1 | B_X0);
        checks++;
        if (obs !== RESET_VIEW) begin
            errors++;
            $display("FAIL x1_x0_together: got %h expected %h", obs, RESET_VIEW);
        end
        press(B_ADD);
        checks++;
        if (op_code !== 2'b01) begin
            errors++;
            $display("FAIL add_select: op_code got %b expected 01", op_code);
        end
        press(B_ADD | B_SUB);
        checks++;
        if (op_code !== 2'b01) begin
            errors++;
            $display("FAIL add_sub_together: op_code got %b expected 01", op_code);
        end
        press(B_SUB);
        checks++;
        if (op_code !== 2'b10) begin
            errors++;
            $display("FAIL sub_select: op_code got %b expected 10", op_code);
        end
    endtask

    task automatic test_clr_midway();
        do_reset();
        enter_nibble(4'b1011);
        press(B_X0);
        press(B_X1);
        checks++;
        if ({entering_b, bit_idx, op_b} !== {1'b1, 2'd1, 4'b0100}) begin
            errors++;
            $display("FAIL mid_b_setup: got %b/%0d/%b expected 1/1/0100", entering_b, bit_idx, op_b);
        end
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== RESET_VIEW) begin
            errors++;
            $display("FAIL clr_in_enter_b: got %h expected %h", obs, RESET_VIEW);
        end
        enter_nibble(4'b0101);
        enter_nibble(4'b1010);
        press(B_ADD);
        press(B_RES);
        checks++;
        if (req_valid !== 1'b1) begin
            errors++;
            $display("FAIL issue_before_clr: req_valid got %b expected 1", req_valid);
        end
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== RESET_VIEW) begin
            errors++;
            $display("FAIL clr_in_issue: got %h expected %h", obs, RESET_VIEW);
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_transfer();
        test_no_op();
        test_conflicts();
        test_clr_midway();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
